// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Grants one requester, pulses tx_start, tracks tx_busy, then enforces an idle gap.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned SRC_W        = 2,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [SRC_W-1:0]     tx_src,
  output logic                 frame_done,
  output logic                 launch_err,
  output logic                 active
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaitBusy = 2'd1;
  localparam logic [1:0] StWaitDone = 2'd2;
  localparam logic [1:0] StGap      = 2'd3;

  localparam int unsigned CntMax = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  // Timeout fires on the edge that ends cycle BUSY_TIMEOUT-1 after tx_start.
  localparam logic [CntW-1:0] BusyLimit = CntW'(BUSY_TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLimit  = CntW'(GAP_CYCLES);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic               frame_done_q, frame_done_d;
  logic               launch_err_q, launch_err_d;
  logic               active_q, active_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [SRC_W-1:0]   tx_src_q, tx_src_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               found;
  logic [SRC_W-1:0]   win;
  logic [SRC_W-1:0]   cand;
  logic [7:0]         req_byte [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  // Search upward from last+1, wrapping, so the last winner is considered last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((32'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    launch_err_d = 1'b0;
    active_d     = active_q;
    tx_data_d    = tx_data_q;
    tx_src_d     = tx_src_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (found && !tx_busy) begin
          tx_data_d  = req_byte[win];
          tx_src_d   = win;
          ack_d[win] = 1'b1;
          tx_start_d = 1'b1;
          active_d   = 1'b1;
          last_d     = win;
          cnt_d      = '0;
          state_d    = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q == BusyLimit) begin
          launch_err_d = 1'b1;
          cnt_d        = '0;
          state_d      = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLimit) begin
          active_d = 1'b0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      launch_err_q <= 1'b0;
      active_q     <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_src_q     <= '0;
      last_q       <= SRC_W'(NUM_REQ - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
      launch_err_q <= launch_err_d;
      active_q     <= active_d;
      tx_data_q    <= tx_data_d;
      tx_src_q     <= tx_src_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack        = ack_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign tx_src     = tx_src_q;
  assign frame_done = frame_done_q;
  assign launch_err = launch_err_q;
  assign active     = active_q;

endmodule
